// File: rtl/ibuf_mux_sched_if.sv
// ibuf_mux_sched_if: job control, request/grant and output handshake bundle for ibuf_mux_sched
interface ibuf_mux_sched_if #(
    parameter int NREQ  = 8,
    parameter int CNT_W = 16
);
    logic                    start;
    logic                    abort;
    logic [CNT_W-1:0]        cfg_beats;
    logic [CNT_W-1:0]        cfg_grants;
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         grant;
    logic [$clog2(NREQ)-1:0] mux_ctrl;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;
    logic                    done;
    modport master (
        output start, abort, cfg_beats, cfg_grants, req, out_ready,
        input  grant, mux_ctrl, out_valid, busy, done
    );
    modport slave (
        input  start, abort, cfg_beats, cfg_grants, req, out_ready,
        output grant, mux_ctrl, out_valid, busy, done
    );
endinterface

// File: rtl/ibuf_mux_sched.sv
// ibuf_mux_sched: round-robin scheduler driving an 8:1 window mux with per-grant beat bursts
module ibuf_mux_sched #(
    parameter int NREQ  = 8,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    ibuf_mux_sched_if.slave bus
);
    localparam int SW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, ARB, XFER, DONE} state_t;
    state_t           state, state_d;
    logic [NREQ-1:0]  grant_d;
    logic [SW-1:0]    mux_d, last, last_d, sel, idx;
    logic             valid_d, busy_d, done_d, found;
    logic [CNT_W-1:0] beats, beats_d, grants, grants_d;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_d, grant_cnt, grant_cnt_d;
    // Scan from last+1 upward; descending loop lets the nearest set bit win.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = last + SW'(k);
            if (bus.req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_d     = state;
        grant_d     = bus.grant;
        mux_d       = bus.mux_ctrl;
        valid_d     = bus.out_valid;
        last_d      = last;
        beats_d     = beats;
        grants_d    = grants;
        beat_cnt_d  = beat_cnt;
        grant_cnt_d = grant_cnt;
        if (state != IDLE && bus.abort) begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    beats_d     = (bus.cfg_beats == '0) ? CNT_W'(1) : bus.cfg_beats;
                    grants_d    = (bus.cfg_grants == '0) ? CNT_W'(1) : bus.cfg_grants;
                    grant_cnt_d = '0;
                    state_d     = ARB;
                end
                ARB: if (found) begin
                    grant_d    = NREQ'(1) << sel;
                    mux_d      = sel;
                    last_d     = sel;
                    beat_cnt_d = beats;
                    valid_d    = 1'b1;
                    state_d    = XFER;
                end
                XFER: if (bus.out_valid && bus.out_ready) begin
                    beat_cnt_d = beat_cnt - CNT_W'(1);
                    if (beat_cnt == CNT_W'(1)) begin
                        grant_d     = '0;
                        valid_d     = 1'b0;
                        grant_cnt_d = grant_cnt + CNT_W'(1);
                        state_d     = (grant_cnt + CNT_W'(1) == grants) ? DONE : ARB;
                    end
                end
                DONE: state_d = IDLE;
            endcase
        end
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.grant     <= '0;
            bus.mux_ctrl  <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            last          <= '1;
            beats         <= '0;
            grants        <= '0;
            beat_cnt      <= '0;
            grant_cnt     <= '0;
        end else begin
            state         <= state_d;
            bus.grant     <= grant_d;
            bus.mux_ctrl  <= mux_d;
            bus.out_valid <= valid_d;
            bus.busy      <= busy_d;
            bus.done      <= done_d;
            last          <= last_d;
            beats         <= beats_d;
            grants        <= grants_d;
            beat_cnt      <= beat_cnt_d;
            grant_cnt     <= grant_cnt_d;
        end
    end
endmodule

// File: tb/tb_ibuf_mux_sched.sv
// tb_ibuf_mux_sched: directed checks of grant/mux_ctrl/out_valid/busy/done against hand-derived values
module tb_ibuf_mux_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    ibuf_mux_sched_if bus ();
    ibuf_mux_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [13:0] e(logic [7:0] g, logic [2:0] m, logic v, logic b, logic d);
        return {g, m, v, b, d};
    endfunction
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    // Packed observation is {grant, mux_ctrl, out_valid, busy, done}.
    task automatic chk(string tag, logic [13:0] exp_v);
        logic [13:0] obs;
        obs = {bus.grant, bus.mux_ctrl, bus.out_valid, bus.busy, bus.done};
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed g=%h m=%0d v=%b b=%b d=%b, expected g=%h m=%0d v=%b b=%b d=%b",
                   tag, obs[13:6], obs[5:3], obs[2], obs[1], obs[0],
                   exp_v[13:6], exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask
    task automatic go();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask
    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_beats = '0; bus.cfg_grants = '0;
        bus.req = '0; bus.out_ready = 1'b0;
        #1 chk("reset", e(8'h00, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        // three grants of two beats, all requesters ready
        bus.cfg_beats = 16'd2; bus.cfg_grants = 16'd3; bus.req = 8'hFF; bus.out_ready = 1'b1;
        go();          chk("s1_arb0", e(8'h00, 0, 0, 1, 0));
        step();        chk("s1_g0_b1", e(8'h01, 0, 1, 1, 0));
        step();        chk("s1_g0_b2", e(8'h01, 0, 1, 1, 0));
        step();        chk("s1_arb1", e(8'h00, 0, 0, 1, 0));
        step();        chk("s1_g1", e(8'h02, 1, 1, 1, 0));
        step(); step(); chk("s1_arb2", e(8'h00, 1, 0, 1, 0));
        step();        chk("s1_g2", e(8'h04, 2, 1, 1, 0));
        step();        chk("s1_g2_b2", e(8'h04, 2, 1, 1, 0));
        step();        chk("s1_done", e(8'h00, 2, 0, 1, 1));
        step();        chk("s1_idle", e(8'h00, 2, 0, 0, 0));
        // wrap between bits 7 and 2 starting from last = 2
        bus.cfg_beats = 16'd1; bus.cfg_grants = 16'd4; bus.req = 8'b1000_0100;
        go();          chk("s2_arb", e(8'h00, 2, 0, 1, 0));
        step();        chk("s2_g7a", e(8'h80, 7, 1, 1, 0));
        step();        chk("s2_arb_a", e(8'h00, 7, 0, 1, 0));
        step();        chk("s2_g2a", e(8'h04, 2, 1, 1, 0));
        step(); step(); chk("s2_g7b", e(8'h80, 7, 1, 1, 0));
        step(); step(); chk("s2_g2b", e(8'h04, 2, 1, 1, 0));
        step();        chk("s2_done", e(8'h00, 2, 0, 1, 1));
        step();        chk("s2_idle", e(8'h00, 2, 0, 0, 0));
        // stall with out_ready low, then drop req while still granted
        bus.cfg_beats = 16'd3; bus.cfg_grants = 16'd2; bus.req = 8'h10; bus.out_ready = 1'b0;
        go(); step();  chk("s3_g4", e(8'h10, 4, 1, 1, 0));
        bus.req = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step(); chk("s3_stall", e(8'h10, 4, 1, 1, 0));
        end
        bus.out_ready = 1'b1;
        step();        chk("s3_b1", e(8'h10, 4, 1, 1, 0));
        step();        chk("s3_b2", e(8'h10, 4, 1, 1, 0));
        step();        chk("s3_b3_arb", e(8'h00, 4, 0, 1, 0));
        step();        chk("s3_arb_wait", e(8'h00, 4, 0, 1, 0));
        bus.abort = 1'b1;
        step();        chk("s3_abort_arb", e(8'h00, 4, 0, 0, 0));
        bus.abort = 1'b0;
        // abort on the final handshake: no done
        bus.cfg_beats = 16'd1; bus.cfg_grants = 16'd1; bus.req = 8'h01;
        go(); step();  chk("s4_g0", e(8'h01, 0, 1, 1, 0));
        bus.abort = 1'b1;
        step();        chk("s4_abort", e(8'h00, 0, 0, 0, 0));
        bus.abort = 1'b0;
        step();        chk("s4_nodone", e(8'h00, 0, 0, 0, 0));
        // start with abort in IDLE still starts
        bus.req = 8'h00; bus.start = 1'b1; bus.abort = 1'b1;
        step();        chk("s5_start_abort", e(8'h00, 0, 0, 1, 0));
        bus.start = 1'b0;
        step();        chk("s5_abort", e(8'h00, 0, 0, 0, 0));
        bus.abort = 1'b0;
        // async reset mid-transfer, then a fresh job with cfg_beats = 0
        bus.cfg_beats = 16'd2; bus.cfg_grants = 16'd1; bus.req = 8'hFF; bus.out_ready = 1'b0;
        go(); step();  chk("s6_g1", e(8'h02, 1, 1, 1, 0));
        #2 rst_n = 1'b0;
        #1 chk("s6_async_rst", e(8'h00, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step();        chk("s6_no_resume", e(8'h00, 0, 0, 0, 0));
        bus.cfg_beats = 16'd0; bus.cfg_grants = 16'd2; bus.out_ready = 1'b1;
        go();          chk("s6_arb", e(8'h00, 0, 0, 1, 0));
        step();        chk("s6_g0", e(8'h01, 0, 1, 1, 0));
        step();        chk("s6_one_beat", e(8'h00, 0, 0, 1, 0));
        step();        chk("s6_g1b", e(8'h02, 1, 1, 1, 0));
        step();        chk("s6_done", e(8'h00, 1, 0, 1, 1));
        step();        chk("s6_idle", e(8'h00, 1, 0, 0, 0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
